pow_5_issue_ctrl: RTL

- Issue controller in front of the multi-cycle x^5 unit.
- Buffers incoming operands in a small FIFO and issues them one at a time, because the unit is not pipelined.
- Holds each operand stable for the whole computation, captures the result, and presents it on a ready/valid output stream.
- Sits between the operand producer and the pow-5 unit; also acts as the unit's result consumer.

---
 rtl/pow_5_issue_ctrl_if.sv | 27 ++
 rtl/pow_5_issue_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pow_5_issue_ctrl_if.sv
// Operand, result and pow-5 unit handshake bundle for pow_5_issue_ctrl.
// slave  : the issue controller (accepts operands, drives results and the unit issue).
// master : the surrounding system (operand producer, result consumer, pow-5 unit).
interface pow_5_issue_ctrl_if #(
  parameter int W = 8
) ();
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] in_data;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_data;
  logic         pow_n_vld;
  logic [W-1:0] pow_n;
  logic         pow_res_vld;
  logic [W-1:0] pow_res;

  modport slave (
    input  in_vld, in_data, out_rdy, pow_res_vld, pow_res,
    output in_rdy, out_vld, out_data, pow_n_vld, pow_n
  );

  modport master (
    output in_vld, in_data, out_rdy, pow_res_vld, pow_res,
    input  in_rdy, out_vld, out_data, pow_n_vld, pow_n
  );
endinterface

// File: rtl/pow_5_issue_ctrl.sv
// Issue controller for the non-pipelined x^5 unit: queues operands in a small
// FIFO, issues one at a time, holds the operand until the result returns and
// offers the result on a ready/valid stream.
// Optional watchdog on the unit: define POW5_ISSUE_TIMEOUT_EN to add err_o.
//
// state  | meaning
// S_IDLE | no operation in flight; issue the FIFO head if there is one
// S_WAIT | operand issued, pow_n held, waiting for pow_res_vld
// S_HOLD | result presented on out_*, waiting for the downstream to take it
module pow_5_issue_ctrl #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pow_5_issue_ctrl_if.slave      bus,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] fifo_cnt_o
`ifdef POW5_ISSUE_TIMEOUT_EN
  ,
  output logic                   err_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("pow_5_issue_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   pow_n_q, pow_n_d;
  logic           pow_n_vld_q, pow_n_vld_d;
  logic           out_vld_q, out_vld_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           push, pop;

`ifdef POW5_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           err_q, err_d;
  assign err_o = err_q;
`endif

  // in_rdy depends only on reset and occupancy, never on in_vld
  assign bus.in_rdy    = !rst_i && (cnt_q != CW'(DEPTH));
  assign push          = bus.in_vld && bus.in_rdy;
  assign cnt_d         = cnt_q + CW'(push) - CW'(pop);
  assign busy_o        = (state_q != S_IDLE) || (cnt_q != '0);
  assign fifo_cnt_o    = cnt_q;
  assign bus.pow_n     = pow_n_q;
  assign bus.pow_n_vld = pow_n_vld_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.out_data  = out_data_q;

  // Next-state and registered-output logic for the issue FSM
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    pow_n_d     = pow_n_q;
    pow_n_vld_d = 1'b0;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
`ifdef POW5_ISSUE_TIMEOUT_EN
    tmr_d       = tmr_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop         = 1'b1;
          pow_n_d     = mem_q[rd_ptr_q];
          pow_n_vld_d = 1'b1;
          state_d     = S_WAIT;
`ifdef POW5_ISSUE_TIMEOUT_EN
          tmr_d       = TW'(TIMEOUT - 1);
`endif
        end
      end
      S_WAIT: begin
        // a result arriving on the terminal-count cycle still wins
        if (bus.pow_res_vld) begin
          out_data_d = bus.pow_res;
          out_vld_d  = 1'b1;
          state_d    = S_HOLD;
        end
`ifdef POW5_ISSUE_TIMEOUT_EN
        else if (tmr_q == '0) begin
          err_d   = 1'b1;
          pow_n_d = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
`endif
      end
      S_HOLD: begin
        if (bus.out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, FIFO pointers/count and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pow_n_q     <= '0;
      pow_n_vld_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
`ifdef POW5_ISSUE_TIMEOUT_EN
      tmr_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_q + PW'(push);
      rd_ptr_q    <= rd_ptr_q + PW'(pop);
      cnt_q       <= cnt_d;
      pow_n_q     <= pow_n_d;
      pow_n_vld_q <= pow_n_vld_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
`ifdef POW5_ISSUE_TIMEOUT_EN
      tmr_q       <= tmr_d;
      err_q       <= err_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since the count gates every read
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

endmodule
